// File: rtl/mnist_image_memory_pkg.sv
// Shared sizing constants and controller state type for the MNIST image store.
package mnist_image_memory_pkg;

   localparam int unsigned GRID_SIZE = 28;
   localparam int unsigned DEPTH     = GRID_SIZE * GRID_SIZE;
   localparam int unsigned ADDR_W    = 16;
   localparam int unsigned DATA_W    = 32;
   localparam int unsigned MEM_AW    = $clog2(DEPTH);

   localparam logic [ADDR_W-1:0] DEPTH_ADDR = ADDR_W'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEPTH - 1);
   localparam logic [MEM_AW-1:0] LAST_MEM   = MEM_AW'(DEPTH - 1);

   typedef enum logic {
      CLEAR,
      RUN
   } state_t;

endpackage

// File: rtl/mnist_image_memory_image_ram.sv
// DEPTH x DATA_W single-write, registered-read, read-first block RAM.
module image_ram
   import mnist_image_memory_pkg::*;
(
   input  logic                     clk,
   input  logic                     we,
   input  logic [MEM_AW-1:0]        waddr,
   input  logic signed [DATA_W-1:0] wdata,
   input  logic [MEM_AW-1:0]        raddr,
   input  logic                     rd_zero,
   output logic signed [DATA_W-1:0] q
);

   logic signed [DATA_W-1:0] mem [DEPTH];

   // Read and write share one edge; the registered read sees the pre-write word.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (rd_zero) begin
         q <= '0;
      end else begin
         q <= mem[raddr];
      end
   end

endmodule

// File: rtl/mnist_image_memory.sv
// 28x28 pixel store: self-clearing sweep after reset, then user writes, with a free-running read scan.
module mnist_image_memory
   import mnist_image_memory_pkg::*;
(
   input  logic                     CLOCK_50,
   input  logic                     reset,
   input  logic [ADDR_W-1:0]        write_addr,
   input  logic signed [DATA_W-1:0] data_in,
   input  logic                     write_enable,
   output logic [ADDR_W-1:0]        read_addr,
   output logic signed [DATA_W-1:0] data_out
);

   state_t                   state, state_next;
   logic [MEM_AW-1:0]        clear_ptr, clear_ptr_next;
   logic                     ram_we;
   logic [MEM_AW-1:0]        ram_waddr;
   logic signed [DATA_W-1:0] ram_wdata;

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state     <= CLEAR;
         clear_ptr <= '0;
         read_addr <= '0;
      end else begin
         state     <= state_next;
         clear_ptr <= clear_ptr_next;
         read_addr <= (read_addr == LAST_ADDR) ? '0 : read_addr + 1'b1;
      end
   end

   always_comb begin
      state_next     = state;
      clear_ptr_next = clear_ptr;
      ram_we         = 1'b0;
      ram_waddr      = write_addr[MEM_AW-1:0];
      ram_wdata      = data_in;
      case (state)
         CLEAR: begin
            ram_we         = 1'b1;
            ram_waddr      = clear_ptr;
            ram_wdata      = '0;
            clear_ptr_next = clear_ptr + 1'b1;
            if (clear_ptr == LAST_MEM) begin
               clear_ptr_next = '0;
               state_next     = RUN;
            end
         end
         RUN: begin
            // Out-of-range addresses must not alias onto the truncated RAM index.
            ram_we = write_enable && (write_addr < DEPTH_ADDR);
         end
         default: state_next = CLEAR;
      endcase
   end

   // The output register is zeroed on the last CLEAR edge too, hiding stale words mid-sweep.
   image_ram u_ram (
      .clk     (CLOCK_50),
      .we      (ram_we & ~reset),
      .waddr   (ram_waddr),
      .wdata   (ram_wdata),
      .raddr   (read_addr[MEM_AW-1:0]),
      .rd_zero (reset | (state == CLEAR)),
      .q       (data_out)
   );

endmodule

// File: tb/tb_mnist_image_memory.sv
// Scoreboard bench for mnist_image_memory: driver pushes expected scan outputs, negedge monitor compares.
module tb_mnist_image_memory;

   logic               CLOCK_50 = 1'b0;
   logic               reset = 1'b1;
   logic [15:0]        write_addr = '0;
   logic signed [31:0] data_in = '0;
   logic               write_enable = 1'b0;
   logic [15:0]        read_addr;
   logic signed [31:0] data_out;

   mnist_image_memory dut (
      .CLOCK_50     (CLOCK_50),
      .reset        (reset),
      .write_addr   (write_addr),
      .data_in      (data_in),
      .write_enable (write_enable),
      .read_addr    (read_addr),
      .data_out     (data_out)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   typedef struct {
      logic [15:0]        ra;
      logic signed [31:0] d;
      string              tag;
   } exp_t;

   exp_t               sb[$];
   logic signed [31:0] golden [784];
   int                 cyc = 0;
   logic [15:0]        cur_ra = '0;
   int                 n_checks = 0;
   int                 n_fail = 0;

   always @(negedge CLOCK_50) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         n_checks++;
         if (read_addr !== e.ra || data_out !== e.d) begin
            n_fail++;
            $display("FAIL scan_%s: got read_addr=%0d data_out=%0d, expected read_addr=%0d data_out=%0d",
                     e.tag, read_addr, data_out, e.ra, e.d);
         end
      end
   end

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // One clock: apply inputs, then push what the outputs must be after that edge.
   // Edges 1..784 after release form the clear sweep; scan position is cycles-since-release mod 784.
   task automatic tick(input logic r, input logic we, input logic [15:0] wa,
                       input logic signed [31:0] wd, input string tag);
      exp_t e;
      reset = r; write_enable = we; write_addr = wa; data_in = wd;
      @(posedge CLOCK_50); #1;
      if (r) begin
         cyc = 0;
         foreach (golden[i]) golden[i] = '0;
         e.ra = '0;
         e.d  = '0;
      end else begin
         cyc++;
         e.ra = 16'(cyc % 784);
         e.d  = (cyc <= 784) ? 32'sd0 : golden[(cyc - 1) % 784];
         if (cyc > 784 && we && wa < 16'd784) golden[int'(wa)] = wd;
      end
      e.tag  = tag;
      cur_ra = e.ra;
      sb.push_back(e);
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 16'd0, 32'sd0, tag);
   endtask

   // Runs until the DUT scan reaches ra, then checks the word read one cycle earlier.
   task automatic check_at(input logic [15:0] ra, input logic signed [31:0] exp, input string name);
      for (int i = 0; i < 800; i++) begin
         tick(1'b0, 1'b0, 16'd0, 32'sd0, name);
         if (read_addr == ra) begin
            cmp(name, data_out, exp);
            return;
         end
      end
      n_checks++;
      n_fail++;
      $display("FAIL %s: read_addr never reached %0d within 800 cycles", name, ra);
   endtask

   initial begin
      // 1: reset, then clear sweep with write_enable pulses that must be ignored
      for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 16'd0, 32'sd0, "reset");
      cmp("reset_read_addr", 32'(read_addr), 32'd0);
      cmp("reset_data_out", data_out, 32'sd0);
      for (int i = 0; i < 784; i++)
         tick(1'b0, (i % 97) == 5, 16'(i + 3), 32'sh1234, "clear");
      cmp("clear_done_read_addr", 32'(read_addr), 32'd0);
      idle(790, "blank");

      // 2: single pixel at (1,1)
      tick(1'b0, 1'b1, 16'd29, 32'sd1, "wr29");
      check_at(16'd30, 32'sd1, "pix29");
      check_at(16'd31, 32'sd0, "pix30");

      // 3: last address, out-of-range drop, and an aliasing candidate
      tick(1'b0, 1'b1, 16'd783, -32'sd5, "wr783");
      tick(1'b0, 1'b1, 16'd784, 32'sd7, "wr784");
      tick(1'b0, 1'b1, 16'd1029, 32'sd9, "wr1029");
      check_at(16'd0, -32'sd5, "pix783");
      check_at(16'd1, 32'sd0, "pix0");
      check_at(16'd6, 32'sd0, "pix5_noalias");

      // 4: read-during-write collision is read-first
      tick(1'b0, 1'b1, 16'd100, 32'sd17, "wr100a");
      idle(790, "pass");
      for (int i = 0; i < 800 && cur_ra != 16'd100; i++) idle(1, "align");
      tick(1'b0, 1'b1, 16'd100, 32'sd85, "rdw");
      cmp("rdw_old", data_out, 32'sd17);
      check_at(16'd101, 32'sd85, "rdw_new");

      // 6: wrap 782 -> 783 -> 0 -> 1
      check_at(16'd782, 32'sd0, "pix781");
      idle(1, "wrap");
      cmp("wrap_783", 32'(read_addr), 32'd783);
      idle(1, "wrap");
      cmp("wrap_0", 32'(read_addr), 32'd0);
      cmp("wrap_0_data", data_out, -32'sd5);
      idle(1, "wrap");
      cmp("wrap_1", 32'(read_addr), 32'd1);

      // 5: reset mid-RUN clears everything after the re-run sweep
      idle(37, "prerst");
      tick(1'b1, 1'b0, 16'd0, 32'sd0, "midreset");
      cmp("midrst_read_addr", 32'(read_addr), 32'd0);
      cmp("midrst_data_out", data_out, 32'sd0);
      tick(1'b1, 1'b1, 16'd29, 32'sd3, "midreset");
      idle(784, "reclear");
      check_at(16'd30, 32'sd0, "pix29_cleared");
      check_at(16'd0, 32'sd0, "pix783_cleared");
      check_at(16'd101, 32'sd0, "pix100_cleared");

      @(negedge CLOCK_50); #1;
      n_checks++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
